seven_segment_disp: RTL and testbench
=====================================

// Module: seven_segment_disp
// PURPOSE
//   Converts a 5-bit binary value (0..31) into two 7-segment digit patterns (tens, ones).
//   Sits between counter/score logic and the board display pins.
//   Outputs are registered, giving glitch-free pin drive.
// PARAMETERS
//   ACTIVE_LOW  0  1 = invert all segment outputs (common-anode display); 0 = segment lit when bit=1
// PORTS
//   clk         in   1  system clock, rising edge
//   rst_n       in   1  asynchronous active-low reset
//   en          in   1  load enable; 1 = sample number this cycle, 0 = hold outputs
//   number      in   5  unsigned binary value 0..31
//   tens_digit  out  7  segment pattern of tens digit, bit order {g,f,e,d,c,b,a}
//   ones_digit  out  7  segment pattern of ones digit, same bit order
// BEHAVIOUR
//   - One clock, one asynchronous active-low reset (rst_n); all state resets asynchronously.
//   - Reset: tens_digit = ones_digit = all segments off (7'h00 active-high, 7'h7F if ACTIVE_LOW=1).
//   - Split: tens = number / 10 (0..3), ones = number % 10 (0..9); pure combinational, no iteration.
//   - Latency: 1 cycle; outputs update on the first rising clk edge where en=1 after number changes.
//   - en=0: outputs hold their last value indefinitely.
//   - Encoding (active-high): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
//   - The 5-bit input has no out-of-range values: 31 -> tens 3, ones 1.
//     The encoder still maps BCD 10..15 to blank (00) as a defensive default.
//   - ACTIVE_LOW applies a final bitwise inversion after encoding, before the output register.
//   - Reset asserted mid-operation blanks outputs immediately, with no clock required.
//     After rst_n deasserts, the next en=1 edge loads normally.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN
//     defined:     when number < 10, tens_digit shows the blank pattern instead of "0".
//     not defined: tens_digit always shows the digit; 0..9 display "0" in the tens position.
//   The ones digit is never blanked; 0 always displays as "0" on the ones digit.
// STRUCTURE
//   Package seven_segment_pkg:
//     - SEG_0..SEG_9 and SEG_BLANK localparams (7-bit, active-high)
//     - a seg_t typedef for the 7-bit pattern
//   Sub-module seg7_digit_encoder:
//     - combinational 4-bit BCD -> 7-bit active-high pattern
//     - instantiated twice (tens, ones)
//   Top-level logic:
//     - divide/modulo-by-10 split of the 5-bit input
//     - polarity inversion, optional blanking, output registers with load enable
// TESTING
//   1. rst_n=0 with number=17 and en=1 -> both outputs 00; no change on clk edges while held.
//   2. Release reset, en=1, number=0 -> after one edge tens=3F, ones=3F
//      (tens=00 with LEADING_ZERO_BLANK_EN).
//   3. Sweep number 0..31 with en=1, one per cycle -> each output is the previous cycle's value.
//      Spot checks: 17->06/07, 29->5B/6F, 31->4F/06, 10->06/3F.
//   4. number=23, en=1, then en=0 and number=5 for 3 cycles -> outputs remain 5B/4F.
//   5. ACTIVE_LOW=1, number=8 -> tens=40 (or 7F blanked with the macro), ones=00; reset value 7F/7F.
//   6. Assert rst_n low between clock edges while outputs show 31 -> outputs blank immediately,
//      with no clock edge required.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - segment patterns and pattern type shared by the display logic
package seven_segment_pkg;

    // Bit order {g,f,e,d,c,b,a}, active-high (1 = segment lit)
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'h3F;
    localparam seg_t SEG_1     = 7'h06;
    localparam seg_t SEG_2     = 7'h5B;
    localparam seg_t SEG_3     = 7'h4F;
    localparam seg_t SEG_4     = 7'h66;
    localparam seg_t SEG_5     = 7'h6D;
    localparam seg_t SEG_6     = 7'h7D;
    localparam seg_t SEG_7     = 7'h07;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h6F;
    localparam seg_t SEG_BLANK = 7'h00;

    localparam int unsigned NUM_W = 5;
    localparam int unsigned BCD_W = 4;

    // Mask applied after encoding; all-ones flips to common-anode drive
    function automatic seg_t polarity_mask(input bit active_low);
        return active_low ? 7'h7F : 7'h00;
    endfunction

endpackage

// File: rtl/seg7_digit_encoder.sv
// rtl/seg7_digit_encoder.sv - combinational 4-bit BCD to active-high 7-segment pattern
module seg7_digit_encoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            // 10..15 cannot come from the splitter but stay dark rather than show garbage
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_disp.sv
// rtl/seven_segment_disp.sv - registered two-digit 7-segment driver for a 0..31 value; LEADING_ZERO_BLANK_EN blanks a zero tens digit
module seven_segment_disp
    import seven_segment_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] number,
    output logic [6:0] tens_digit,
    output logic [6:0] ones_digit
);

    localparam seg_t POL_MASK = polarity_mask(ACTIVE_LOW);
    localparam seg_t OFF_PAT  = SEG_BLANK ^ POL_MASK;

    logic [1:0] tens_val;
    logic [4:0] tens_times_ten;
    logic [4:0] ones_full;
    logic [3:0] tens_bcd;
    logic [3:0] ones_bcd;
    seg_t       tens_enc;
    seg_t       ones_enc;
    seg_t       tens_shown;
    seg_t       tens_next;
    seg_t       ones_next;

    // Range compare instead of a divider: the quotient can only be 0..3
    always_comb begin
        tens_val       = 2'd0;
        tens_times_ten = 5'd0;
        if (number >= 5'd30) begin
            tens_val       = 2'd3;
            tens_times_ten = 5'd30;
        end else if (number >= 5'd20) begin
            tens_val       = 2'd2;
            tens_times_ten = 5'd20;
        end else if (number >= 5'd10) begin
            tens_val       = 2'd1;
            tens_times_ten = 5'd10;
        end
    end

    assign ones_full = number - tens_times_ten;
    assign ones_bcd  = ones_full[3:0];
    assign tens_bcd  = {2'b00, tens_val};

    seg7_digit_encoder u_tens_enc (
        .bcd (tens_bcd),
        .seg (tens_enc)
    );

    seg7_digit_encoder u_ones_enc (
        .bcd (ones_bcd),
        .seg (ones_enc)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign tens_shown = (tens_val == 2'd0) ? SEG_BLANK : tens_enc;
`else
    assign tens_shown = tens_enc;
`endif

    assign tens_next = tens_shown ^ POL_MASK;
    assign ones_next = ones_enc ^ POL_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_digit <= OFF_PAT;
            ones_digit <= OFF_PAT;
        end else if (en) begin
            tens_digit <= tens_next;
            ones_digit <= ones_next;
        end
    end

endmodule

// File: tb/tb_seven_segment_disp.sv
// tb/tb_seven_segment_disp.sv - randomized self-checking bench for seven_segment_disp, both polarities
module tb_seven_segment_disp;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [4:0] number;
    logic [6:0] tens_h, ones_h, tens_l, ones_l;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [0:9];
    bit         loaded;
    int         cur;

    seven_segment_disp #(.ACTIVE_LOW(1'b0)) dut_h (
        .clk(clk), .rst_n(rst_n), .en(en), .number(number),
        .tens_digit(tens_h), .ones_digit(ones_h)
    );

    seven_segment_disp #(.ACTIVE_LOW(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .en(en), .number(number),
        .tens_digit(tens_l), .ones_digit(ones_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] model_tens(input int n, input bit al);
        logic [6:0] p;
        p = seg_tbl[n / 10];
`ifdef LEADING_ZERO_BLANK_EN
        if (n < 10) p = 7'h00;
`endif
        return al ? ~p : p;
    endfunction

    function automatic logic [6:0] model_ones(input int n, input bit al);
        logic [6:0] p;
        p = seg_tbl[n % 10];
        return al ? ~p : p;
    endfunction

    task automatic check_outputs(input string tag);
        if (!loaded) begin
            check({tag, "/tens_h"}, tens_h, 7'h00);
            check({tag, "/ones_h"}, ones_h, 7'h00);
            check({tag, "/tens_l"}, tens_l, 7'h7F);
            check({tag, "/ones_l"}, ones_l, 7'h7F);
        end else begin
            check({tag, "/tens_h"}, tens_h, model_tens(cur, 1'b0));
            check({tag, "/ones_h"}, ones_h, model_ones(cur, 1'b0));
            check({tag, "/tens_l"}, tens_l, model_tens(cur, 1'b1));
            check({tag, "/ones_l"}, ones_l, model_ones(cur, 1'b1));
        end
    endtask

    // One clock: inputs already driven, model follows the load enable, check at the falling edge
    task automatic step(input string tag);
        @(posedge clk);
        if (rst_n && en) begin
            loaded = 1'b1;
            cur    = int'(number);
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        seg_tbl[0] = 7'h3F; seg_tbl[1] = 7'h06; seg_tbl[2] = 7'h5B; seg_tbl[3] = 7'h4F;
        seg_tbl[4] = 7'h66; seg_tbl[5] = 7'h6D; seg_tbl[6] = 7'h7D; seg_tbl[7] = 7'h07;
        seg_tbl[8] = 7'h7F; seg_tbl[9] = 7'h6F;
        loaded = 1'b0;
        cur    = 0;

        rst_n  = 1'b0;
        en     = 1'b1;
        number = 5'd17;
        for (int i = 0; i < 3; i++) step("reset_hold");

        rst_n  = 1'b1;
        number = 5'd0;
        step("first_load_0");
`ifdef LEADING_ZERO_BLANK_EN
        check("first_load_tens_const", tens_h, 7'h00);
`else
        check("first_load_tens_const", tens_h, 7'h3F);
`endif
        check("first_load_ones_const", ones_h, 7'h3F);

        for (int n = 0; n < 32; n++) begin
            number = 5'(n);
            step("sweep");
            case (n)
                17: begin check("spot17_t", tens_h, 7'h06); check("spot17_o", ones_h, 7'h07); end
                29: begin check("spot29_t", tens_h, 7'h5B); check("spot29_o", ones_h, 7'h6F); end
                31: begin check("spot31_t", tens_h, 7'h4F); check("spot31_o", ones_h, 7'h06); end
                10: begin check("spot10_t", tens_h, 7'h06); check("spot10_o", ones_h, 7'h3F); end
                default: ;
            endcase
        end

        number = 5'd23;
        en     = 1'b1;
        step("hold_load");
        en     = 1'b0;
        number = 5'd5;
        for (int i = 0; i < 3; i++) begin
            step("hold");
            check("hold_tens_const", tens_h, 7'h5B);
            check("hold_ones_const", ones_h, 7'h4F);
        end

        en     = 1'b1;
        number = 5'd8;
        step("al_eight");
`ifdef LEADING_ZERO_BLANK_EN
        check("al8_tens_const", tens_l, 7'h7F);
`else
        check("al8_tens_const", tens_l, 7'h40);
`endif
        check("al8_ones_const", ones_l, 7'h00);

        for (int i = 0; i < 300; i++) begin
            en     = 1'($urandom_range(0, 1));
            number = 5'($urandom_range(0, 31));
            step("random");
        end

        en     = 1'b1;
        number = 5'd31;
        step("pre_async");
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        loaded = 1'b0;
        #1;
        check_outputs("async_reset");
        @(negedge clk);
        check_outputs("async_reset_held");
        rst_n  = 1'b1;
        number = 5'd9;
        step("post_reset_load");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
